// File: rtl/ram8_bus_master.sv
// ram8_bus_master: turns valid/ready requests into timed cycles on a registered
// single-port RAM bus (addr / shared data / rw / cs / oe). All RAM-side controls
// and the response outputs come straight from flops.
module ram8_bus_master #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  wr_done,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   inout  wire  [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_rw,
   output logic                  ram_cs,
   output logic                  ram_oe
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD_A,
      ST_RD_D,
      ST_TURN
   } state_t;

   // Number of extra RD_D cycles; the hold counter counts up to this value.
   localparam logic [3:0] HOLD_LAST = 4'(WAIT_STATES);

   state_t                state_q,      state_d;
   logic [3:0]            hold_cnt_q,   hold_cnt_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q,   ram_addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                  wr_done_q,    wr_done_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  ram_cs_q,     ram_cs_d;
   logic                  ram_oe_q,     ram_oe_d;
   logic                  ram_rw_q,     ram_rw_d;
   logic                  drive_q,      drive_d;
   logic                  req_ready_q,  req_ready_d;

   // Next-state logic; RAM controls are decoded from the next state so that they
   // are registered and line up exactly with the state they belong to.
   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      ram_addr_d   = ram_addr_q;
      wdata_d      = wdata_q;
      resp_rdata_d = resp_rdata_q;
      wr_done_d    = 1'b0;
      resp_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               ram_addr_d = req_addr;
               wdata_d    = req_wdata;
               state_d    = req_we ? ST_WR : ST_RD_A;
            end
         end
         ST_WR: begin
            // RAM commits at the edge closing WR; report it in the following cycle.
            wr_done_d = 1'b1;
            state_d   = ST_IDLE;
         end
         ST_RD_A: begin
            hold_cnt_d = 4'd0;
            state_d    = ST_RD_D;
         end
         ST_RD_D: begin
            if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + 4'd1;
            end else begin
               resp_rdata_d = ram_data;
               resp_valid_d = 1'b1;
               state_d      = ST_TURN;
            end
         end
         ST_TURN: begin
            // Dead cycle: neither side drives the bus before the next op.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ram_cs_d    = (state_d == ST_WR) || (state_d == ST_RD_A) || (state_d == ST_RD_D);
      ram_oe_d    = (state_d == ST_RD_A) || (state_d == ST_RD_D);
      ram_rw_d    = (state_d == ST_WR);
      drive_d     = (state_d == ST_WR);
      req_ready_d = (state_d == ST_IDLE);
   end

   // State and output registers; reset releases the bus immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         hold_cnt_q   <= 4'd0;
         ram_addr_q   <= '0;
         wdata_q      <= '0;
         resp_rdata_q <= '0;
         wr_done_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         ram_cs_q     <= 1'b0;
         ram_oe_q     <= 1'b0;
         ram_rw_q     <= 1'b0;
         drive_q      <= 1'b0;
         req_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         ram_addr_q   <= ram_addr_d;
         wdata_q      <= wdata_d;
         resp_rdata_q <= resp_rdata_d;
         wr_done_q    <= wr_done_d;
         resp_valid_q <= resp_valid_d;
         ram_cs_q     <= ram_cs_d;
         ram_oe_q     <= ram_oe_d;
         ram_rw_q     <= ram_rw_d;
         drive_q      <= drive_d;
         req_ready_q  <= req_ready_d;
      end
   end

   assign ram_data   = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
   assign req_ready  = req_ready_q;
   assign wr_done    = wr_done_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign ram_addr   = ram_addr_q;
   assign ram_rw     = ram_rw_q;
   assign ram_cs     = ram_cs_q;
   assign ram_oe     = ram_oe_q;

endmodule
